// File: rtl/irq_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : irq_sequencer
//  Purpose  : Multi-channel interrupt sequencer. Accepts NUM_IRQ maskable,
//             prioritised requests (lowest unmasked index wins). On acceptance
//             it stalls fetch, waits for the pipeline to drain, pushes the
//             resume PC as 16-bit words (most significant first), then the
//             zero-extended flags, loads the per-channel vector into the PC
//             and holds in-service until end-of-interrupt.
//  Ports    : clk, rst (async, active-low)
//             irq_in/mask_we/mask_data   - request lines and mask register
//             pipe_empty/mem_busy        - pipeline drain / push backpressure
//             resume_pc/flags            - context captured at drain end
//             eoi                        - RTI retired, ends service
//             stall_fetch/push_valid/push_data/pc_write/pc_value
//             irq_active/irq_id/pending  - status
//  Revision : 1.0 - initial release
// ============================================================================
module irq_sequencer #(
   parameter int unsigned NUM_IRQ       = 4,
   parameter int unsigned PC_WIDTH      = 32,
   parameter int unsigned FLAG_WIDTH    = 3,
   parameter logic [NUM_IRQ-1:0]  EDGE_MASK     = '1,
   parameter logic [PC_WIDTH-1:0] VECTOR_BASE   = '0,
   parameter logic [PC_WIDTH-1:0] VECTOR_STRIDE = PC_WIDTH'(2),
   localparam int unsigned ID_W = $clog2(NUM_IRQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_IRQ-1:0]    irq_in,
   input  logic                  mask_we,
   input  logic [NUM_IRQ-1:0]    mask_data,
   input  logic                  pipe_empty,
   input  logic                  mem_busy,
   input  logic [PC_WIDTH-1:0]   resume_pc,
   input  logic [FLAG_WIDTH-1:0] flags,
   input  logic                  eoi,
   output logic                  stall_fetch,
   output logic                  push_valid,
   output logic [15:0]           push_data,
   output logic                  pc_write,
   output logic [PC_WIDTH-1:0]   pc_value,
   output logic                  irq_active,
   output logic [ID_W-1:0]       irq_id,
   output logic [NUM_IRQ-1:0]    pending
);

   localparam int unsigned C_PC_WORDS = PC_WIDTH / 16;
   localparam int unsigned C_CNT_W    = (C_PC_WORDS > 1) ? $clog2(C_PC_WORDS) : 1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_DRAIN    = 3'd1,
      S_PUSH_PC  = 3'd2,
      S_PUSH_FLG = 3'd3,
      S_VECTOR   = 3'd4,
      S_SERVICE  = 3'd5
   } state_t;

   state_t                r_state;
   logic [NUM_IRQ-1:0]    r_mask;
   logic [NUM_IRQ-1:0]    r_prev_irq;
   logic [PC_WIDTH-1:0]   r_pc_sh;   // captured PC, shifted up as words go out
   logic [FLAG_WIDTH-1:0] r_flags;
   logic [C_CNT_W-1:0]    r_cnt;     // words still to push after the current one

   logic [NUM_IRQ-1:0]    w_eligible;
   logic [NUM_IRQ-1:0]    w_rise;
   logic [NUM_IRQ-1:0]    w_accept_clr;
   logic [ID_W-1:0]       w_winner;
   logic                  w_accept;
   logic [PC_WIDTH-1:0]   w_vector;

   assign w_eligible = pending & ~r_mask;
   assign w_rise     = irq_in & ~r_prev_irq;
   assign w_accept   = (r_state == S_IDLE) && (w_eligible != '0);
   assign w_vector   = VECTOR_BASE + (PC_WIDTH'(irq_id) * VECTOR_STRIDE);

   // Lowest eligible index wins: scan downward so the last hit is the lowest.
   always_comb begin
      w_winner = '0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_winner = ID_W'(i);
         end
      end
   end

   always_comb begin
      w_accept_clr = '0;
      if (w_accept) begin
         w_accept_clr[w_winner] = 1'b1;
      end
   end

   // Request capture. Edge channels: a rising edge in the same cycle as the
   // acceptance clear wins. Level channels simply mirror the registered line.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prev_irq <= '0;
         r_mask     <= '1;
         pending    <= '0;
      end else begin
         r_prev_irq <= irq_in;
         if (mask_we) begin
            r_mask <= mask_data;
         end
         pending <= (EDGE_MASK & ((pending & ~w_accept_clr) | w_rise))
                  | (~EDGE_MASK & irq_in);
      end
   end

   // Sequencer. Outputs are registered and loaded together with the state
   // they belong to, so they always reflect the current registered state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         irq_id      <= '0;
         stall_fetch <= 1'b0;
         push_valid  <= 1'b0;
         push_data   <= '0;
         pc_write    <= 1'b0;
         pc_value    <= '0;
         irq_active  <= 1'b0;
         r_pc_sh     <= '0;
         r_flags     <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state     <= S_DRAIN;
                  irq_id      <= w_winner;
                  stall_fetch <= 1'b1;
               end
            end
            S_DRAIN: begin
               if (pipe_empty) begin
                  r_state    <= S_PUSH_PC;
                  push_valid <= 1'b1;
                  push_data  <= resume_pc[PC_WIDTH-1 -: 16];
                  r_pc_sh    <= resume_pc << 16;
                  r_flags    <= flags;
                  r_cnt      <= C_CNT_W'(C_PC_WORDS - 1);
               end
            end
            S_PUSH_PC: begin
               if (!mem_busy) begin
                  if (r_cnt == '0) begin
                     r_state   <= S_PUSH_FLG;
                     push_data <= 16'(r_flags);
                  end else begin
                     r_cnt     <= r_cnt - C_CNT_W'(1);
                     push_data <= r_pc_sh[PC_WIDTH-1 -: 16];
                     r_pc_sh   <= r_pc_sh << 16;
                  end
               end
            end
            S_PUSH_FLG: begin
               // Fetch stays frozen here; it is released only in SERVICE.
               if (!mem_busy) begin
                  r_state    <= S_VECTOR;
                  push_valid <= 1'b0;
                  push_data  <= '0;
                  pc_write   <= 1'b1;
                  pc_value   <= w_vector;
               end
            end
            S_VECTOR: begin
               r_state     <= S_SERVICE;
               pc_write    <= 1'b0;
               pc_value    <= '0;
               stall_fetch <= 1'b0;
               irq_active  <= 1'b1;
            end
            S_SERVICE: begin
               if (eoi) begin
                  r_state    <= S_IDLE;
                  irq_active <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/irq_sequencer.md
# irq_sequencer

Parametrised multi-channel interrupt sequencer for the pipelined processor. It replaces the single `interrupt_signal` wire with `NUM_IRQ` maskable, prioritised request lines. On acceptance it stalls fetch and waits for the pipeline to drain. It then pushes the resume PC as 16-bit words, most-significant first, followed by the flags, redirects the PC to a per-channel vector, and holds in-service until end-of-interrupt.

## Interface
- `NUM_IRQ`, 4: number of request channels; must be ≥2. `ID_W = $clog2(NUM_IRQ)`.
- `PC_WIDTH`, 32: PC width; must be a multiple of 16. `PC_WORDS = PC_WIDTH/16`.
- `FLAG_WIDTH`, 3: flag register width; must be ≤16.
- `EDGE_MASK`, all ones: per channel, 1 = rising-edge latched, 0 = level-sensitive.
- `VECTOR_BASE`, 0: PC of the channel-0 vector.
- `VECTOR_STRIDE`, 2: PC distance between consecutive vectors.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `irq_in`  in  NUM_IRQ  request lines, synchronous to `clk`.
- `mask_we`  in  1  write enable for `mask_data`.
- `mask_data`  in  NUM_IRQ  new mask; 1 = channel masked.
- `pipe_empty`  in  1  decode, execute and memory hold only bubbles.
- `mem_busy`  in  1  memory stage cannot accept a push this cycle.
- `resume_pc`  in  PC_WIDTH  address of the next unexecuted instruction, from fetch.
- `flags`  in  FLAG_WIDTH  current flag register.
- `eoi`  in  1  RTI retired; ends service.
- `stall_fetch`  out  1  freeze the PC and the fetch register.
- `push_valid`  out  1  stack push request to the memory stage.
- `push_data`  out  16  word to push.
- `pc_write`  out  1  one-cycle PC load.
- `pc_value`  out  PC_WIDTH  vector address.
- `irq_active`  out  1  a handler is in service.
- `irq_id`  out  ID_W  channel being sequenced or serviced.
- `pending`  out  NUM_IRQ  registered pending vector.

## Operation
- **Reset values:** every output is 0. The mask is all ones (all channels masked). `pending` is 0. `prev_irq` is 0. The state is IDLE.
- **Pending logic:**
  - Edge channels set `pending[i]` on the clock edge where `irq_in[i]`=1 and `prev_irq[i]`=0.
  - A pending bit is cleared only at acceptance of that channel. Set and clear in the same cycle resolve to set.
  - Level channels: `pending[i]` equals the registered `irq_in[i]`. Acceptance does not clear it.
- **Selection:** `eligible = pending & ~mask`. The lowest eligible index wins.
- **Mask writes:** a mask write takes effect at the next edge and does not clear pending bits.
- **FSM states:** IDLE, DRAIN, PUSH_PC, PUSH_FLG, VECTOR, SERVICE.
  - **IDLE:** if `eligible` is nonzero, latch the winner into `irq_id`, clear its edge-pending bit, and go to DRAIN.
  - **DRAIN:** `stall_fetch`=1. When `pipe_empty`=1, capture `resume_pc` and `flags`, set the word counter to `PC_WORDS-1`, and go to PUSH_PC.
  - **PUSH_PC:** `stall_fetch`=1, `push_valid`=1, `push_data` = captured PC word[counter].
    - If `mem_busy`=0, decrement the counter.
    - If the counter is 0 and `mem_busy`=0, go to PUSH_FLG.
    - If `mem_busy`=1, hold the state and data.
  - **PUSH_FLG:** `push_valid`=1, `push_data` = zero-extended flags. Hold while `mem_busy`; otherwise go to VECTOR.
  - **VECTOR:** `pc_write`=1 and `pc_value = VECTOR_BASE + irq_id*VECTOR_STRIDE`, computed in PC_WIDTH with wrap-around. `stall_fetch`=1. Go to SERVICE.
  - **SERVICE:** `irq_active`=1 and `stall_fetch`=0. New requests only accumulate as pending (no nesting). On `eoi`=1, go to IDLE.
- `eoi` is ignored in every state other than SERVICE.
- All outputs are Moore-decoded from registered state.
- **Reset mid-sequence:** reset aborts the sequence immediately. No partial push is retried.

## Timing
- A request edge sampled at edge N sets `pending` at N.
- IDLE accepts the request at edge N+1. `stall_fetch` is high from the cycle after N+1.
- The minimum sequence, with `pipe_empty` already 1 and no `mem_busy`, is DRAIN 1 cycle, PUSH_PC `PC_WORDS` cycles, PUSH_FLG 1 cycle, VECTOR 1 cycle.
  - For the defaults this is 5 cycles from DRAIN entry to the SERVICE edge.
- Each `mem_busy` cycle adds exactly one cycle.
- `push_valid` is never asserted in back-to-back cycles for the same word unless `mem_busy` was 1.
- After `eoi` in SERVICE, a still-eligible channel is accepted no earlier than one cycle after the return to IDLE.

## Test plan
- **Basic sequence:** reset, `mask_we` with 4'b0000, edge on `irq_in[2]`, `pipe_empty`=1, `resume_pc`=32'h0001_0234, `flags`=3'b101.
  - Pushes 16'h0001, 16'h0234, 16'h0005 on three consecutive cycles.
  - `pc_value`=4 with `pc_write` for one cycle, then `irq_active`=1 and `irq_id`=2.
- **Priority:** edges on channels 3 and 1 in the same cycle.
  - Channel 1 is serviced first.
  - After `eoi`, channel 3 is sequenced with `pc_value`=6.
- **Mask and backpressure:** channel 0 masked with a request.
  - No sequence while masked.
  - Unmasking starts DRAIN within 2 cycles.
  - `mem_busy` held 3 cycles during the first push keeps `push_data`=PC high word stable for 4 cycles.
- **Drain wait:** `pipe_empty`=0 for 5 cycles.
  - `stall_fetch`=1 throughout with no push.
  - The first push occurs the cycle after `pipe_empty` rises.
- **No nesting:** a request on channel 0 during SERVICE of channel 3.
  - `pending[0]`=1 but no state change.
  - `eoi` is ignored outside SERVICE.
- **Reset mid-sequence:** `rst` low during PUSH_PC.
  - All outputs go to 0 asynchronously, the mask returns to all ones, and the state returns to IDLE.
